// File: rtl/cpu_fsm.sv
// cpu_fsm -- instruction sequencer for the register-file/ALU datapath.
//
// Takes one decoded instruction per start pulse and steps the datapath
// through it one strobe set per cycle. Supported: MOV imm, MOV reg, ADD,
// CMP, AND, MVN. Any other opcode is dropped with a one-cycle illegal pulse.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   reset_n  : synchronous active-low reset
//   s        : start, sampled only while idle (w=1)
//   opcode   : 110 MOV class, 101 ALU class
//   op       : MOV 10 imm / 00 reg; ALU 00 ADD, 01 CMP, 10 AND, 11 MVN
//   w        : idle / ready for s
//   nsel     : register select 100 Rn, 010 Rd, 001 Rm, 000 none
//   loada/b/c/s : datapath register load enables
//   asel     : ALU A input forced to 0
//   bsel     : ALU B from sximm5 (never used by this instruction set)
//   vsel     : writeback source 00 C reg, 01 sximm8
//   write    : register-file write enable
//   illegal  : pulse while an unsupported opcode sits in decode
//
// All outputs come straight from flops. They are computed from the state
// and instruction the FSM is about to enter, so they line up with the state
// register without a combinational path from any input.

module cpu_fsm (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       illegal
);

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;

  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b01;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WR_IMM,
    S_GET_A,
    S_GET_B,
    S_COMPUTE,
    S_WR_REG
  } state_t;

  // Instruction class, derived from the raw opcode/op pair.
  typedef enum logic [2:0] {
    K_MOVI,
    K_MOVR,
    K_ADD,
    K_CMP,
    K_AND,
    K_MVN,
    K_ILL
  } kind_t;

  // One flop per output pin, grouped so reset and update are one assignment.
  typedef struct packed {
    logic       w;
    logic [2:0] nsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic       write;
    logic       illegal;
  } ctl_t;

  function automatic kind_t classify(input logic [2:0] opc, input logic [1:0] sub);
    kind_t k;
    k = K_ILL;
    if (opc == OPC_MOV) begin
      // MOV only defines op 10 (imm) and 00 (reg); 01/11 are illegal.
      case (sub)
        2'b10:   k = K_MOVI;
        2'b00:   k = K_MOVR;
        default: k = K_ILL;
      endcase
    end else if (opc == OPC_ALU) begin
      case (sub)
        2'b00:   k = K_ADD;
        2'b01:   k = K_CMP;
        2'b10:   k = K_AND;
        default: k = K_MVN;
      endcase
    end
    return k;
  endfunction

  function automatic state_t next_state(input state_t st, input logic start,
                                        input kind_t k);
    state_t n;
    n = S_WAIT;
    case (st)
      S_WAIT:   n = start ? S_DECODE : S_WAIT;
      S_DECODE: begin
        case (k)
          K_MOVI:               n = S_WR_IMM;
          K_MOVR, K_MVN:        n = S_GET_B;   // single-operand ops skip Rn
          K_ADD, K_CMP, K_AND:  n = S_GET_A;
          default:              n = S_WAIT;    // illegal: drop it
        endcase
      end
      S_WR_IMM:  n = S_WAIT;
      S_GET_A:   n = S_GET_B;
      S_GET_B:   n = S_COMPUTE;
      S_COMPUTE: n = (k == K_CMP) ? S_WAIT : S_WR_REG;  // CMP only sets flags
      S_WR_REG:  n = S_WAIT;
      default:   n = S_WAIT;
    endcase
    return n;
  endfunction

  // Moore output table: strobes for a state given the instruction it runs.
  function automatic ctl_t ctl_of(input state_t st, input kind_t k);
    ctl_t c;
    c = '0;
    c.nsel = NSEL_NONE;
    case (st)
      S_WAIT:   c.w = 1'b1;
      S_DECODE: c.illegal = (k == K_ILL);
      S_WR_IMM: begin
        c.nsel  = NSEL_RN;
        c.vsel  = VSEL_IMM8;
        c.write = 1'b1;
      end
      S_GET_A: begin
        c.nsel  = NSEL_RN;
        c.loada = 1'b1;
      end
      S_GET_B: begin
        c.nsel  = NSEL_RM;
        c.loadb = 1'b1;
      end
      S_COMPUTE: begin
        // MOV reg and MVN pass B through, so A is forced to 0.
        c.asel  = (k == K_MOVR) || (k == K_MVN);
        c.bsel  = 1'b0;
        c.loads = (k == K_CMP);
        c.loadc = (k != K_CMP);
      end
      S_WR_REG: begin
        c.nsel  = NSEL_RD;
        c.vsel  = VSEL_C;
        c.write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t     state;
  logic [2:0] ir_opc;
  logic [1:0] ir_op;
  ctl_t       ctl;

  // Instruction capture happens only on the edge leaving WAIT with s=1.
  logic       capture;
  logic [2:0] ir_opc_n;
  logic [1:0] ir_op_n;
  kind_t      kind_cur;
  kind_t      kind_n;
  state_t     state_n;
  ctl_t       ctl_n;

  assign capture  = (state == S_WAIT) && s;
  assign ir_opc_n = capture ? opcode : ir_opc;
  assign ir_op_n  = capture ? op     : ir_op;
  assign kind_cur = classify(ir_opc, ir_op);
  assign kind_n   = classify(ir_opc_n, ir_op_n);
  assign state_n  = next_state(state, s, kind_cur);
  assign ctl_n    = ctl_of(state_n, kind_n);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= S_WAIT;
      ir_opc <= '0;
      ir_op  <= '0;
      ctl    <= ctl_of(S_WAIT, K_ILL);
    end else begin
      state  <= state_n;
      ir_opc <= ir_opc_n;
      ir_op  <= ir_op_n;
      ctl    <= ctl_n;
    end
  end

  assign w       = ctl.w;
  assign nsel    = ctl.nsel;
  assign loada   = ctl.loada;
  assign loadb   = ctl.loadb;
  assign loadc   = ctl.loadc;
  assign loads   = ctl.loads;
  assign asel    = ctl.asel;
  assign bsel    = ctl.bsel;
  assign vsel    = ctl.vsel;
  assign write   = ctl.write;
  assign illegal = ctl.illegal;

endmodule

// File: tb/tb_cpu_fsm.sv
// Bench for cpu_fsm: directed cases plus a randomized instruction stream,
// each instruction compared cycle by cycle against the busy-cycle sequence
// listed for its class.
module tb_cpu_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic       loada, loadb, loadc, loads, asel, bsel;
  logic [1:0] vsel;
  logic       write, illegal;

  cpu_fsm dut (
    .clk(clk), .reset_n(reset_n), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel), .write(write),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, illegal}
  function automatic logic [13:0] pk(input logic w_, input logic [2:0] ns,
      input logic la, input logic lb, input logic lc, input logic ls,
      input logic as_, input logic [1:0] vs, input logic wr, input logic il);
    return {w_, ns, la, lb, lc, ls, as_, 1'b0, vs, wr, il};
  endfunction

  function automatic logic [13:0] obs();
    return {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, illegal};
  endfunction

  localparam logic [13:0] V_IDLE = 14'b1_000_0000_0_0_00_0_0;

  // Reference: busy-cycle sequence per instruction, straight from the
  // instruction description (decode, operand fetch, compute, writeback).
  logic [13:0] exp_q[$];
  int          exp_writes;

  task automatic build(input logic [2:0] opc, input logic [1:0] sub);
    logic [13:0] dec, geta, getb, wreg;
    dec  = pk(0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    geta = pk(0, 3'b100, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    getb = pk(0, 3'b001, 0, 1, 0, 0, 0, 2'b00, 0, 0);
    wreg = pk(0, 3'b010, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    exp_q.delete();
    exp_writes = 0;
    if (opc == 3'b110 && sub == 2'b10) begin          // MOV imm
      exp_q = '{dec, pk(0, 3'b100, 0, 0, 0, 0, 0, 2'b01, 1, 0)};
      exp_writes = 1;
    end else if (opc == 3'b110 && sub == 2'b00) begin // MOV reg
      exp_q = '{dec, getb, pk(0, 3'b000, 0, 0, 1, 0, 1, 2'b00, 0, 0), wreg};
      exp_writes = 1;
    end else if (opc == 3'b101 && sub == 2'b11) begin // MVN
      exp_q = '{dec, getb, pk(0, 3'b000, 0, 0, 1, 0, 1, 2'b00, 0, 0), wreg};
      exp_writes = 1;
    end else if (opc == 3'b101 && sub == 2'b01) begin // CMP
      exp_q = '{dec, geta, getb, pk(0, 3'b000, 0, 0, 0, 1, 0, 2'b00, 0, 0)};
    end else if (opc == 3'b101) begin                 // ADD / AND
      exp_q = '{dec, geta, getb, pk(0, 3'b000, 0, 0, 1, 0, 0, 2'b00, 0, 0), wreg};
      exp_writes = 1;
    end else begin                                    // illegal
      exp_q = '{pk(0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 0, 1)};
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n_instr = 0;

  // Starts from a WAIT cycle, runs one instruction, ends in the next WAIT
  // cycle (unchecked; the caller or next call checks it).
  // zero_opc: hold opcode at 000 during execution instead of random junk.
  task automatic run_instr(input logic [2:0] opc, input logic [1:0] sub,
                           input logic zero_opc);
    int wr_seen;
    string tag;
    build(opc, sub);
    n_instr++;
    chk($sformatf("i%0d idle-before", n_instr), 32'(obs()), 32'(V_IDLE));
    s = 1'b1; opcode = opc; op = sub;
    step();
    wr_seen = 0;
    for (int c = 0; c < exp_q.size(); c++) begin
      // Busy-time inputs must be ignored, including s.
      s      = 1'($urandom_range(0, 1));
      opcode = zero_opc ? 3'b000 : 3'($urandom);
      op     = 2'($urandom);
      tag = $sformatf("i%0d op%0b/%0b cyc%0d", n_instr, opc, sub, c);
      chk(tag, 32'(obs()), 32'(exp_q[c]));
      if (write) wr_seen++;
      step();
    end
    s = 1'b0;
    chk($sformatf("i%0d done-w", n_instr), 32'(w), 32'd1);
    chk($sformatf("i%0d writes", n_instr), 32'(wr_seen), 32'(exp_writes));
  endtask

  initial begin
    reset_n = 1'b0; s = 1'b1; opcode = 3'b110; op = 2'b10;
    // Reset held with s=1: must stay idle.
    step();
    chk("rst0", 32'(obs()), 32'(V_IDLE));
    step();
    chk("rst1", 32'(obs()), 32'(V_IDLE));
    reset_n = 1'b1; s = 1'b0;
    step();
    chk("rst-released", 32'(obs()), 32'(V_IDLE));

    // Directed cases.
    run_instr(3'b110, 2'b10, 1'b0);   // MOV R3,#-5
    run_instr(3'b101, 2'b00, 1'b0);   // ADD
    run_instr(3'b101, 2'b01, 1'b1);   // CMP, opcode zeroed mid-flight
    run_instr(3'b101, 2'b11, 1'b0);   // MVN back-to-back
    run_instr(3'b111, 2'b00, 1'b0);   // illegal
    run_instr(3'b110, 2'b01, 1'b0);   // MOV with reserved op
    run_instr(3'b110, 2'b00, 1'b0);   // MOV reg
    run_instr(3'b101, 2'b10, 1'b0);   // AND

    // Reset during GET_B of an ADD.
    chk("mr idle", 32'(obs()), 32'(V_IDLE));
    s = 1'b1; opcode = 3'b101; op = 2'b00;
    step();                            // DECODE
    s = 1'b0;
    step();                            // GET_A
    chk("mr geta", 32'(obs()), 32'(pk(0, 3'b100, 1, 0, 0, 0, 0, 2'b00, 0, 0)));
    step();                            // GET_B
    chk("mr getb", 32'(obs()), 32'(pk(0, 3'b001, 0, 1, 0, 0, 0, 2'b00, 0, 0)));
    reset_n = 1'b0; s = 1'b1;
    step();
    chk("mr aborted", 32'(obs()), 32'(V_IDLE));
    reset_n = 1'b1; s = 1'b0;
    step();
    chk("mr still idle", 32'(obs()), 32'(V_IDLE));
    run_instr(3'b110, 2'b10, 1'b0);

    // Randomized stream with idle gaps of 0..2 cycles.
    for (int i = 0; i < 80; i++) begin
      logic [2:0] ro;
      logic [1:0] rs;
      int gap;
      case ($urandom_range(0, 3))
        0:       ro = 3'b110;
        1, 2:    ro = 3'b101;
        default: ro = 3'($urandom);
      endcase
      rs = 2'($urandom);
      run_instr(ro, rs, 1'b0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        opcode = 3'($urandom); op = 2'($urandom);
        chk($sformatf("gap%0d.%0d", i, g), 32'(obs()), 32'(V_IDLE));
        step();
      end
    end
    chk("final idle", 32'(obs()), 32'(V_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
